// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcode and ALU_Sel encodings plus immediate extraction
// helpers shared by the ALU issue stage and its decoder.
package alu_issue_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_ADDW = 4'b1010;
    localparam logic [3:0] ALU_SUBW = 4'b1011;
    localparam logic [3:0] ALU_SLLW = 4'b1100;
    localparam logic [3:0] ALU_SRLW = 4'b1101;
    localparam logic [3:0] ALU_SRAW = 4'b1110;

    // I-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    // S-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    // U-type immediate (upper 20 bits, low 12 zero)
    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

    // funct3 map shared by OP and OP-IMM; alt picks SUB/SRA
    function automatic logic [3:0] base_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] s;
        case (f3)
            3'b000:  s = alt ? ALU_SUB : ALU_ADD;
            3'b001:  s = ALU_SLL;
            3'b010:  s = ALU_SLT;
            3'b011:  s = ALU_SLTU;
            3'b100:  s = ALU_XOR;
            3'b101:  s = alt ? ALU_SRA : ALU_SRL;
            3'b110:  s = ALU_OR;
            default: s = ALU_AND;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_op_issue_if.sv
// alu_op_issue_if: upstream beat and downstream ALU handshake bundle.
// slave = issue stage side, master = producer/consumer (test) side.
interface alu_op_issue_if #(parameter int DWIDTH = 32);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DWIDTH-1:0] pc;
    logic [DWIDTH-1:0] rs1_data;
    logic [DWIDTH-1:0] rs2_data;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] in_a;
    logic [DWIDTH-1:0] in_b;
    logic [3:0]        ALU_Sel;
    logic              illegal;

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, in_a, in_b, ALU_Sel, illegal
    );

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, in_a, in_b, ALU_Sel, illegal
    );
endinterface

// File: rtl/alu_issue_dec.sv
// alu_issue_dec: combinational decode of one instruction into ALU operands,
// ALU_Sel code and an illegal flag. Illegal beats carry zeroed operands/ADD.
import alu_issue_pkg::*;

module alu_issue_dec #(parameter int DWIDTH = 32) (
    input  logic [31:0]       instr,
    input  logic [DWIDTH-1:0] pc,
    input  logic [DWIDTH-1:0] rs1,
    input  logic [DWIDTH-1:0] rs2,
    output logic [DWIDTH-1:0] a,
    output logic [DWIDTH-1:0] b,
    output logic [3:0]        sel,
    output logic              illegal
);
    localparam int SHW = $clog2(DWIDTH);

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic              alt;
    logic              f7_ok;
    logic [DWIDTH-1:0] ext_i;
    logic [DWIDTH-1:0] ext_s;
    logic [DWIDTH-1:0] ext_u;
    logic [DWIDTH-1:0] shamt;
    logic [DWIDTH-1:0] shamt_w;

    assign opc     = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign alt     = (f7 == 7'b0100000);
    assign f7_ok   = (f7 == 7'b0000000) || alt;
    assign ext_i   = DWIDTH'(signed'(imm_i(instr)));
    assign ext_s   = DWIDTH'(signed'(imm_s(instr)));
    assign ext_u   = DWIDTH'(signed'(imm_u(instr)));
    assign shamt   = DWIDTH'(instr[20 +: SHW]);
    assign shamt_w = DWIDTH'(instr[24:20]);

    // opcode-driven operand and operation selection
    always_comb begin
        a       = '0;
        b       = '0;
        sel     = ALU_ADD;
        illegal = 1'b0;
        case (opc)
            OPC_OP: begin
                a   = rs1;
                b   = rs2;
                sel = base_sel(f3, alt);
                if (!f7_ok || (alt && f3 != 3'b000 && f3 != 3'b101))
                    illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                a = rs1;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    b   = shamt;
                    sel = base_sel(f3, (f3 == 3'b101) && instr[30]);
                end else begin
                    b   = ext_i;
                    sel = base_sel(f3, 1'b0);
                end
            end
            OPC_OP_32: begin
                a = rs1;
                b = rs2;
                case (f3)
                    3'b000:  sel = alt ? ALU_SUBW : ALU_ADDW;
                    3'b001:  sel = ALU_SLLW;
                    3'b101:  sel = alt ? ALU_SRAW : ALU_SRLW;
                    default: illegal = 1'b1;
                endcase
                if (!f7_ok || (alt && f3 != 3'b000 && f3 != 3'b101))
                    illegal = 1'b1;
            end
            OPC_OP_IMM_32: begin
                a = rs1;
                case (f3)
                    3'b000: begin b = ext_i;   sel = ALU_ADDW; end
                    3'b001: begin b = shamt_w; sel = ALU_SLLW; end
                    3'b101: begin b = shamt_w; sel = instr[30] ? ALU_SRAW : ALU_SRLW; end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LUI:   begin a = '0;  b = ext_u; end
            OPC_AUIPC: begin a = pc;  b = ext_u; end
            OPC_LOAD:  begin a = rs1; b = ext_i; end
            OPC_STORE: begin a = rs1; b = ext_s; end
            OPC_BRANCH: begin
                a = rs1;
                b = rs2;
                case (f3)
                    3'b000, 3'b001: sel = ALU_SUB;
                    3'b100, 3'b101: sel = ALU_SLT;
                    3'b110, 3'b111: sel = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            a   = '0;
            b   = '0;
            sel = ALU_ADD;
        end
    end
endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: registered issue stage between register-file read and ALU.
// Optional macro ALU_ISSUE_SKID_EN: 2-entry FIFO skid buffer with a
// registered in_ready; otherwise a single output register with
// in_ready = !out_valid || out_ready.
import alu_issue_pkg::*;

module alu_op_issue #(parameter int DWIDTH = 32) (
    input logic          clk,
    input logic          rst,
    alu_op_issue_if.slave bus
);
    typedef struct packed {
        logic [DWIDTH-1:0] a;
        logic [DWIDTH-1:0] b;
        logic [3:0]        sel;
        logic              illegal;
    } entry_t;

    logic [DWIDTH-1:0] dec_a;
    logic [DWIDTH-1:0] dec_b;
    logic [3:0]        dec_sel;
    logic              dec_ill;
    entry_t            dec_e;
    entry_t            head;
    logic              valid;
    logic              push;
    logic              pop;

    alu_issue_dec #(.DWIDTH(DWIDTH)) u_dec (
        .instr   (bus.instr),
        .pc      (bus.pc),
        .rs1     (bus.rs1_data),
        .rs2     (bus.rs2_data),
        .a       (dec_a),
        .b       (dec_b),
        .sel     (dec_sel),
        .illegal (dec_ill)
    );

    assign dec_e = '{a: dec_a, b: dec_b, sel: dec_sel, illegal: dec_ill};
    assign push  = bus.in_valid && bus.in_ready;
    assign pop   = valid && bus.out_ready;

    assign bus.out_valid = valid;
    assign bus.in_a      = head.a;
    assign bus.in_b      = head.b;
    assign bus.ALU_Sel   = head.sel;
    assign bus.illegal   = head.illegal;

`ifdef ALU_ISSUE_SKID_EN
    // head is the presented entry, skid holds the second-oldest beat
    entry_t     skid;
    logic [1:0] count;
    logic [1:0] count_next;
    logic       in_ready_q;

    assign valid        = (count != 2'd0);
    assign bus.in_ready = in_ready_q;

    // occupancy after this cycle's handshakes
    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 2'd1;
        else if (pop && !push)
            count_next = count - 2'd1;
    end

    // FIFO storage and registered ready (no out_ready -> in_ready path)
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            in_ready_q <= 1'b0;
            head       <= '0;
            skid       <= '0;
        end else begin
            count      <= count_next;
            in_ready_q <= (count_next != 2'd2);
            if (push && pop) begin
                if (count == 2'd2) begin
                    head <= skid;
                    skid <= dec_e;
                end else begin
                    head <= dec_e;
                end
            end else if (push) begin
                if (count == 2'd0)
                    head <= dec_e;
                else
                    skid <= dec_e;
            end else if (pop && count == 2'd2) begin
                head <= skid;
            end
        end
    end
`else
    logic valid_q;
    logic rst_done;

    assign valid        = valid_q;
    assign bus.in_ready = rst_done && (!valid_q || bus.out_ready);

    // single output register; rst_done holds in_ready low for a cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_done <= 1'b0;
            valid_q  <= 1'b0;
            head     <= '0;
        end else begin
            rst_done <= 1'b1;
            if (push) begin
                head    <= dec_e;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: directed vector table plus back-pressure and
// reset-while-holding sequences for alu_op_issue.
module tb_alu_op_issue;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    alu_op_issue_if #(.DWIDTH(32)) bus ();

    alu_op_issue #(.DWIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [3:0]  exp_sel;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] ea,
                       input logic [31:0] eb, input logic [3:0] es, input logic ei);
        vec_t v;
        v.name = nm; v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.exp_a = ea; v.exp_b = eb; v.exp_sel = es; v.exp_ill = ei;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int sent;
        int got;
        int first_stall;
        int emitted;
        int exp_stall;

        tests = 0;
        fails = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.instr     = 32'h0;
        bus.pc        = 32'h0;
        bus.rs1_data  = 32'h0;
        bus.rs2_data  = 32'h0;
        rst           = 1'b1;

        add("sub",    32'h40208033, 32'h200, 32'd10,        32'd3,  32'd10,        32'd3,         4'b0001, 1'b0);
        add("srai",   32'h4030D093, 32'h200, 32'h80000000,  32'h22, 32'h80000000,  32'd3,         4'b0111, 1'b0);
        add("auipc",  32'h00001017, 32'h100, 32'h11,        32'h22, 32'h100,       32'h1000,      4'b0000, 1'b0);
        add("add",    32'h002081B3, 32'h200, 32'd5,         32'd7,  32'd5,         32'd7,         4'b0000, 1'b0);
        add("addi",   32'hFFF08093, 32'h200, 32'd20,        32'h22, 32'd20,        32'hFFFFFFFF,  4'b0000, 1'b0);
        add("sltu",   32'h0020B1B3, 32'h200, 32'h11,        32'h22, 32'h11,        32'h22,        4'b0100, 1'b0);
        add("sra",    32'h4020D1B3, 32'h200, 32'h11,        32'h22, 32'h11,        32'h22,        4'b0111, 1'b0);
        add("or",     32'h0020E1B3, 32'h200, 32'h11,        32'h22, 32'h11,        32'h22,        4'b1000, 1'b0);
        add("and",    32'h0020F1B3, 32'h200, 32'h11,        32'h22, 32'h11,        32'h22,        4'b1001, 1'b0);
        add("lui",    32'h123450B7, 32'h200, 32'h11,        32'h22, 32'h0,         32'h12345000,  4'b0000, 1'b0);
        add("lw",     32'h00812083, 32'h200, 32'h11,        32'h22, 32'h11,        32'd8,         4'b0000, 1'b0);
        add("sw",     32'hFE20AE23, 32'h200, 32'h11,        32'h22, 32'h11,        32'hFFFFFFFC,  4'b0000, 1'b0);
        add("blt",    32'h0020C063, 32'h200, 32'h11,        32'h22, 32'h11,        32'h22,        4'b0011, 1'b0);
        add("bgeu",   32'h0020F063, 32'h200, 32'h11,        32'h22, 32'h11,        32'h22,        4'b0100, 1'b0);
        add("br010",  32'h0020A063, 32'h200, 32'h11,        32'h22, 32'h0,         32'h0,         4'b0000, 1'b1);
        add("opc7f",  32'h0000007F, 32'h200, 32'h11,        32'h22, 32'h0,         32'h0,         4'b0000, 1'b1);
        add("alt_or", 32'h4020E1B3, 32'h200, 32'h11,        32'h22, 32'h0,         32'h0,         4'b0000, 1'b1);
        add("mul",    32'h022081B3, 32'h200, 32'h11,        32'h22, 32'h0,         32'h0,         4'b0000, 1'b1);
        add("addw",   32'h002081BB, 32'h200, 32'h11,        32'h22, 32'h11,        32'h22,        4'b1010, 1'b0);
        add("subw",   32'h402081BB, 32'h200, 32'h11,        32'h22, 32'h11,        32'h22,        4'b1011, 1'b0);
        add("sllw",   32'h002091BB, 32'h200, 32'h11,        32'h22, 32'h11,        32'h22,        4'b1100, 1'b0);
        add("srlw",   32'h0020D1BB, 32'h200, 32'h11,        32'h22, 32'h11,        32'h22,        4'b1101, 1'b0);
        add("sraiw",  32'h4040D09B, 32'h200, 32'h11,        32'h22, 32'h11,        32'd4,         4'b1110, 1'b0);
        add("slli",   32'h01F09093, 32'h200, 32'h11,        32'h22, 32'h11,        32'd31,        4'b0010, 1'b0);
        add("xori",   32'h7FF0C093, 32'h200, 32'h11,        32'h22, 32'h11,        32'h7FF,       4'b0101, 1'b0);

        // reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_in_a",      bus.in_a,           32'd0);
        chk("rst_sel",       32'(bus.ALU_Sel),   32'd0);
        chk("rst_illegal",   32'(bus.illegal),   32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", 32'(bus.in_ready),  32'd1);
        chk("rel_out_valid",     32'(bus.out_valid), 32'd0);

        // back-to-back table, out_ready held high
        bus.out_ready = 1'b1;
        foreach (vecs[i]) begin
            bus.in_valid = 1'b1;
            bus.instr    = vecs[i].instr;
            bus.pc       = vecs[i].pc;
            bus.rs1_data = vecs[i].rs1;
            bus.rs2_data = vecs[i].rs2;
            #1;
            chk({vecs[i].name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_valid"},   32'(bus.out_valid), 32'd1);
            chk({vecs[i].name, "_a"},       bus.in_a,           vecs[i].exp_a);
            chk({vecs[i].name, "_b"},       bus.in_b,           vecs[i].exp_b);
            chk({vecs[i].name, "_sel"},     32'(bus.ALU_Sel),   32'(vecs[i].exp_sel));
            chk({vecs[i].name, "_illegal"}, 32'(bus.illegal),   32'(vecs[i].exp_ill));
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // back-pressure: 4 beats, out_ready low for the first 3 cycles
`ifdef ALU_ISSUE_SKID_EN
        exp_stall = 2;
`else
        exp_stall = 1;
`endif
        sent = 0;
        got = 0;
        first_stall = -1;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            bus.out_ready = (cyc >= 3);
            bus.in_valid  = (sent < 4);
            bus.instr     = 32'h002081B3;
            bus.rs1_data  = 32'h100 + 32'(sent);
            bus.rs2_data  = 32'(sent);
            #4;
            if (bus.in_valid && !bus.in_ready && first_stall < 0)
                first_stall = sent;
            if (bus.out_valid && bus.out_ready) begin
                chk("bp_order_a", bus.in_a, 32'h100 + 32'(got));
                chk("bp_order_b", bus.in_b, 32'(got));
                got++;
            end else if (bus.out_valid && cyc < 3) begin
                chk("bp_hold_a", bus.in_a, 32'h100);
            end
            if (bus.in_valid && bus.in_ready)
                sent++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("bp_first_stall", 32'(first_stall), 32'(exp_stall));
        chk("bp_sent", 32'(sent), 32'd4);
        chk("bp_got",  32'(got),  32'd4);
        #4;
        chk("bp_empty", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // illegal beat held under back-pressure, then reset with beats held
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = 32'h0000007F;
        bus.rs1_data  = 32'h55;
        bus.rs2_data  = 32'h66;
        @(posedge clk);
        #1;
        chk("ill_valid",   32'(bus.out_valid), 32'd1);
        chk("ill_flag",    32'(bus.illegal),   32'd1);
        chk("ill_sel",     32'(bus.ALU_Sel),   32'd0);
        chk("ill_a",       bus.in_a,           32'd0);
        bus.instr = 32'h002081B3;
        @(posedge clk);
        #1;
        chk("ill_hold_flag", 32'(bus.illegal), 32'd1);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("mrst_illegal",   32'(bus.illegal),   32'd0);
        chk("mrst_sel",       32'(bus.ALU_Sel),   32'd0);
        chk("mrst_in_b",      bus.in_b,           32'd0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        emitted = 0;
        for (int k = 0; k < 6; k++) begin
            #4;
            if (bus.out_valid)
                emitted++;
            @(posedge clk);
            #1;
        end
        chk("mrst_none_emitted", 32'(emitted), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Registered issue stage that produces the ALU's operand and select interface.
- Accepts one decoded-instruction beat (instr, pc, rs1/rs2 data) over a valid/ready handshake.
- Generates in_a, in_b and the 4-bit ALU_Sel code, and presents them registered to the ALU with its own valid/ready handshake.
- Sits between the register-file read and the ALU. It converts the single-cycle datapath's combinational ALU control into a back-pressurable pipeline stage.

Parameters:
DWIDTH, 32, operand/result width; shift amounts use the low log2(DWIDTH) bits.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat this cycle
instr  input  32  RV instruction word
pc  input  DWIDTH  instruction address
rs1_data  input  DWIDTH  register rs1 value
rs2_data  input  DWIDTH  register rs2 value
out_valid  output  1  issued operation valid
out_ready  input  1  ALU/downstream accepts
in_a  output  DWIDTH  ALU operand A
in_b  output  DWIDTH  ALU operand B
ALU_Sel  output  4  ALU operation code
illegal  output  1  beat carried an unsupported encoding

Behaviour:
- Reset: rst is synchronous and active-high; one clock, clk. While rst is high, and on the first edge after it: out_valid=0, in_a=0, in_b=0, ALU_Sel=0, illegal=0, skid empty, in_ready=0. in_ready rises the cycle after rst falls.
- Reset mid-operation: rst discards all held beats with no output handshake.
- Handshakes:
  - Transfer occurs when valid&&ready.
  - Outputs are stable while out_valid && !out_ready.
  - Latency is 1 cycle from input transfer to out_valid.
  - Full throughput is 1 beat per cycle when out_ready=1.
- ALU_Sel codes: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, ADDW 1010, SUBW 1011, SLLW 1100, SRLW 1101, SRAW 1110.
- Decode by opcode instr[6:0]:
  - OP 0110011:
    - in_a=rs1, in_b=rs2.
    - funct3 000 gives ADD, or SUB when funct7=0100000.
    - funct3 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
    - funct3 101 gives SRL, or SRA when funct7=0100000.
    - funct3 110 OR, 111 AND.
  - OP-IMM 0010011:
    - in_a=rs1, in_b=sign-extended imm[31:20].
    - Same funct3 map; no SUB.
    - Shifts take in_b = zero-extended shamt. instr[30] selects SRA.
  - OP-32 0111011: ADDW, SUBW, SLLW, SRLW, SRAW selected as for OP.
  - OP-IMM-32 0011011: ADDIW→ADDW, SLLIW→SLLW, SRLIW/SRAIW→SRLW/SRAW.
  - LUI 0110111: in_a=0, in_b=imm_u, ADD.
  - AUIPC 0010111: in_a=pc, in_b=imm_u, ADD.
  - LOAD 0000011: rs1+imm_i, ADD.
  - STORE 0100011: rs1+imm_s, ADD.
  - BRANCH 1100011: in_a=rs1, in_b=rs2.
    - BEQ/BNE → SUB.
    - BLT/BGE → SLT.
    - BLTU/BGEU → SLTU.
    - funct3 010/011 are illegal.
- Illegal encodings:
  - Covers any other opcode, funct7 not in {0000000,0100000} for OP/OP-32, and funct7=0100000 with funct3 not 000/101.
  - The beat still issues, with illegal=1, ALU_Sel=0000, in_a=0, in_b=0.
  - Never stalls.
- Simultaneous accept and drain on a full stage is permitted; no bubble inserted.

Optional Feature:
ALU_ISSUE_SKID_EN
- Defined:
  - Adds a 2-entry skid buffer.
  - in_ready is driven from a register: =1 unless both entries are occupied.
  - No combinational path from out_ready to in_ready.
  - Ordering is FIFO.
- Undefined:
  - Single output register.
  - in_ready = !out_valid || out_ready (combinational).

Decomposition:
- Package alu_issue_pkg holds:
  - opcode localparams: OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_BRANCH.
  - 4-bit ALU_Sel constants ALU_ADD..ALU_SRAW.
  - Immediate-extraction functions.
- Sub-module alu_issue_dec: purely combinational decode of {instr, pc, rs1, rs2} → {a, b, sel, illegal}.
- The top level owns the handshake and storage.

Test Plan:
- Reset release: rst high 3 cycles, then low → out_valid=0, ALU_Sel=0, in_ready=1 next cycle.
- SUB beat: instr=0x40208033 (sub x0,x1,x2), rs1=10, rs2=3, out_ready=1 → next cycle out_valid=1, ALU_Sel=0001, in_a=10, in_b=3.
- SRAI beat: instr=0x4030D093 (srai x1,x1,3), rs1=0x80000000 → ALU_Sel=0111, in_b=3.
- AUIPC beat: instr=0x00001017, pc=0x100 → ALU_Sel=0000, in_a=0x100, in_b=0x1000.
- Back-pressure: 4 back-to-back beats with out_ready=0 for 3 cycles →
  - Outputs hold the first beat.
  - in_ready drops (after 1 beat, or after 2 with skid).
  - All 4 beats emerge in order, none lost or duplicated.
- Illegal beat, then reset: instr=0x0000007F → illegal=1, ALU_Sel=0. Then assert rst with 2 beats held → out_valid=0 next cycle, none emitted.
